// File: rtl/bellek_hakem.sv
// bellek_hakem: arbitrates the single-port 512x32 memory between instruction
// fetch and the load/store unit. Byte-masked stores are done as read-modify-write.
module bellek_hakem #(
    parameter bit SABIT_ONCELIK     = 1'b0,
    parameter bit BASLANGIC_ONCELIK = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        buyruk_istek_i,
    input  logic [31:0] buyruk_adres_i,
    output logic        buyruk_hazir_o,
    output logic        buyruk_gecerli_o,
    output logic [31:0] buyruk_veri_o,
    input  logic        veri_istek_i,
    input  logic        veri_yaz_i,
    input  logic [31:0] veri_adres_i,
    input  logic [3:0]  veri_maske_i,
    input  logic [31:0] veri_i,
    output logic        veri_hazir_o,
    output logic        veri_gecerli_o,
    output logic [31:0] veri_o,
    output logic        bellek_wen_o,
    output logic [31:0] bellek_adres_o,
    output logic [31:0] bellek_veri_o,
    input  logic [31:0] bellek_veri_i
);

    typedef enum logic {
        BOSTA,
        BIRLESTIR
    } durum_t;

    durum_t      durum_q, durum_d;
    logic        oncelik_q, oncelik_d;          // 1 = load/store favoured
    logic [31:0] birlesik_q, birlesik_d;        // merged word for masked store
    logic [31:0] buyruk_veri_q, buyruk_veri_d;
    logic [31:0] veri_q, veri_d;
    logic        buyruk_gecerli_q, buyruk_gecerli_d;
    logic        veri_gecerli_q, veri_gecerli_d;
    logic        veri_kazanir;

    // Arbitration, request sequencing and memory port drive.
    // Everything is gated by rst_ni so the combinational outputs fall to
    // zero the moment reset asserts, not at the next edge.
    always_comb begin
        durum_d          = durum_q;
        oncelik_d        = oncelik_q;
        birlesik_d       = birlesik_q;
        buyruk_veri_d    = buyruk_veri_q;
        veri_d           = veri_q;
        buyruk_gecerli_d = 1'b0;
        veri_gecerli_d   = 1'b0;
        veri_kazanir     = 1'b0;
        buyruk_hazir_o   = 1'b0;
        veri_hazir_o     = 1'b0;
        bellek_wen_o     = 1'b0;
        bellek_adres_o   = '0;
        bellek_veri_o    = '0;

        if (rst_ni) begin
            unique case (durum_q)
                BOSTA: begin
                    veri_kazanir = veri_istek_i &&
                                   (!buyruk_istek_i || SABIT_ONCELIK || oncelik_q);
                    if (buyruk_istek_i && !veri_kazanir) begin
                        bellek_adres_o   = buyruk_adres_i;
                        buyruk_hazir_o   = 1'b1;
                        buyruk_veri_d    = bellek_veri_i;
                        buyruk_gecerli_d = 1'b1;
                        oncelik_d        = 1'b1;
                    end else if (veri_istek_i) begin
                        bellek_adres_o = veri_adres_i;
                        if (!veri_yaz_i) begin
                            veri_hazir_o   = 1'b1;
                            veri_d         = bellek_veri_i;
                            veri_gecerli_d = 1'b1;
                            oncelik_d      = 1'b0;
                        end else if (veri_maske_i == 4'b1111) begin
                            bellek_wen_o   = 1'b1;
                            bellek_veri_o  = veri_i;
                            veri_hazir_o   = 1'b1;
                            veri_gecerli_d = 1'b1;
                            oncelik_d      = 1'b0;
                        end else if (veri_maske_i == 4'b0000) begin
                            veri_hazir_o   = 1'b1;
                            veri_gecerli_d = 1'b1;
                            oncelik_d      = 1'b0;
                        end else begin
                            for (int unsigned i = 0; i < 4; i++) begin
                                birlesik_d[8*i +: 8] = veri_maske_i[i] ? veri_i[8*i +: 8]
                                                                       : bellek_veri_i[8*i +: 8];
                            end
                            durum_d = BIRLESTIR;
                        end
                    end
                end
                BIRLESTIR: begin
                    bellek_adres_o = veri_adres_i;
                    bellek_wen_o   = 1'b1;
                    bellek_veri_o  = birlesik_q;
                    veri_hazir_o   = 1'b1;
                    veri_gecerli_d = 1'b1;
                    oncelik_d      = 1'b0;
                    durum_d        = BOSTA;
                end
                default: durum_d = BOSTA;
            endcase
        end
    end

    // State, priority pointer and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q          <= BOSTA;
            oncelik_q        <= BASLANGIC_ONCELIK;
            birlesik_q       <= '0;
            buyruk_veri_q    <= '0;
            veri_q           <= '0;
            buyruk_gecerli_q <= 1'b0;
            veri_gecerli_q   <= 1'b0;
        end else begin
            durum_q          <= durum_d;
            oncelik_q        <= oncelik_d;
            birlesik_q       <= birlesik_d;
            buyruk_veri_q    <= buyruk_veri_d;
            veri_q           <= veri_d;
            buyruk_gecerli_q <= buyruk_gecerli_d;
            veri_gecerli_q   <= veri_gecerli_d;
        end
    end

    assign buyruk_veri_o    = buyruk_veri_q;
    assign veri_o           = veri_q;
    assign buyruk_gecerli_o = buyruk_gecerli_q;
    assign veri_gecerli_o   = veri_gecerli_q;

endmodule

// File: tb/tb_bellek_hakem.sv
// Directed bench for bellek_hakem: round-robin instance with a 512x32 memory
// model, plus a fixed-priority instance sharing the same stimulus.
module tb_bellek_hakem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bi;
    logic [31:0] badr;
    logic        vi;
    logic        vyaz;
    logic [31:0] vadr;
    logic [3:0]  vmaske;
    logic [31:0] vdata;

    logic        b_hazir, b_gec, v_hazir, v_gec, wen;
    logic [31:0] b_veri, v_veri, m_adr, m_wdata, m_rdata;

    logic        b_hazir2, b_gec2, v_hazir2, v_gec2, wen2;
    logic [31:0] b_veri2, v_veri2, m_adr2, m_wdata2, m_rdata2;

    logic [31:0] mem [512];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign m_rdata  = mem[m_adr[10:2]];
    assign m_rdata2 = mem[m_adr2[10:2]];

    // Memory model: asynchronous read, whole-word write on rising edge.
    always @(posedge clk) begin
        if (wen) mem[m_adr[10:2]] <= m_wdata;
    end

    bellek_hakem #(.SABIT_ONCELIK(1'b0), .BASLANGIC_ONCELIK(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .buyruk_istek_i(bi), .buyruk_adres_i(badr),
        .buyruk_hazir_o(b_hazir), .buyruk_gecerli_o(b_gec), .buyruk_veri_o(b_veri),
        .veri_istek_i(vi), .veri_yaz_i(vyaz), .veri_adres_i(vadr),
        .veri_maske_i(vmaske), .veri_i(vdata),
        .veri_hazir_o(v_hazir), .veri_gecerli_o(v_gec), .veri_o(v_veri),
        .bellek_wen_o(wen), .bellek_adres_o(m_adr), .bellek_veri_o(m_wdata),
        .bellek_veri_i(m_rdata)
    );

    bellek_hakem #(.SABIT_ONCELIK(1'b1), .BASLANGIC_ONCELIK(1'b0)) dut_sabit (
        .clk_i(clk), .rst_ni(rst_n),
        .buyruk_istek_i(bi), .buyruk_adres_i(badr),
        .buyruk_hazir_o(b_hazir2), .buyruk_gecerli_o(b_gec2), .buyruk_veri_o(b_veri2),
        .veri_istek_i(vi), .veri_yaz_i(vyaz), .veri_adres_i(vadr),
        .veri_maske_i(vmaske), .veri_i(vdata),
        .veri_hazir_o(v_hazir2), .veri_gecerli_o(v_gec2), .veri_o(v_veri2),
        .bellek_wen_o(wen2), .bellek_adres_o(m_adr2), .bellek_veri_o(m_wdata2),
        .bellek_veri_i(m_rdata2)
    );

    task automatic idle();
        bi = 1'b0; badr = '0; vi = 1'b0; vyaz = 1'b0;
        vadr = '0; vmaske = '0; vdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        bi = 1'b1; badr = 32'h0000_0010;
        #2;
        total++; if (b_hazir !== 1'b0) begin bad++; $display("FAIL rst_hazir got=%b exp=0", b_hazir); end
        total++; if (m_adr !== 32'h0) begin bad++; $display("FAIL rst_adres got=%h exp=0", m_adr); end
        repeat (3) @(posedge clk);
        total++; if (b_veri !== 32'h0 || v_veri !== 32'h0) begin bad++; $display("FAIL rst_veri got=%h/%h exp=0", b_veri, v_veri); end
        total++; if (b_gec !== 1'b0 || v_gec !== 1'b0 || wen !== 1'b0) begin bad++; $display("FAIL rst_gecerli got=%b%b%b exp=000", b_gec, v_gec, wen); end
        #2 rst_n = 1'b1;
        idle();
    endtask

    task automatic test_round_robin();
        mem[2] = 32'h0BAD_F00D;
        mem[3] = 32'hCAFE_0001;
        next_cycle();
        bi = 1'b1; badr = 32'h0000_000C;
        vi = 1'b1; vyaz = 1'b0; vadr = 32'h0000_0008;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (b_hazir !== (c % 2 == 0) || v_hazir !== (c % 2 == 1)) begin
                bad++; $display("FAIL rr_grant c=%0d got b=%b v=%b exp b=%b v=%b", c, b_hazir, v_hazir, c % 2 == 0, c % 2 == 1);
            end
            total++;
            if (m_adr !== ((c % 2 == 0) ? 32'h0000_000C : 32'h0000_0008)) begin
                bad++; $display("FAIL rr_adres c=%0d got=%h", c, m_adr);
            end
            total++;
            if (v_hazir2 !== 1'b1 || b_hazir2 !== 1'b0) begin
                bad++; $display("FAIL sabit_grant c=%0d got b=%b v=%b exp b=0 v=1", c, b_hazir2, v_hazir2);
            end
            next_cycle();
        end
        idle();
        total++; if (v_gec !== 1'b1 || b_gec !== 1'b0) begin bad++; $display("FAIL rr_last_gecerli got b=%b v=%b exp b=0 v=1", b_gec, v_gec); end
        total++; if (v_veri !== 32'h0BAD_F00D) begin bad++; $display("FAIL rr_load_veri got=%h exp=0badf00d", v_veri); end
        total++; if (b_veri !== 32'hCAFE_0001) begin bad++; $display("FAIL rr_fetch_veri got=%h exp=cafe0001", b_veri); end
    endtask

    task automatic test_fetch();
        mem[4] = 32'hDEAD_BEEF;
        next_cycle();
        bi = 1'b1; badr = 32'h0000_0010;
        @(negedge clk);
        total++; if (b_hazir !== 1'b1) begin bad++; $display("FAIL fetch_hazir got=%b exp=1", b_hazir); end
        total++; if (m_adr !== 32'h0000_0010) begin bad++; $display("FAIL fetch_adres got=%h exp=00000010", m_adr); end
        next_cycle();
        idle();
        total++; if (b_gec !== 1'b1) begin bad++; $display("FAIL fetch_gecerli got=%b exp=1", b_gec); end
        total++; if (b_veri !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_veri got=%h exp=deadbeef", b_veri); end
        next_cycle();
        total++; if (b_gec !== 1'b0 || b_veri !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_hold got gec=%b veri=%h exp 0/deadbeef", b_gec, b_veri); end
    endtask

    task automatic test_store_full();
        vi = 1'b1; vyaz = 1'b1; vadr = 32'h0000_0020; vmaske = 4'b1111; vdata = 32'h1122_3344;
        @(negedge clk);
        total++; if (wen !== 1'b1 || v_hazir !== 1'b1) begin bad++; $display("FAIL full_wen got wen=%b hazir=%b exp 1/1", wen, v_hazir); end
        total++; if (m_wdata !== 32'h1122_3344) begin bad++; $display("FAIL full_wdata got=%h exp=11223344", m_wdata); end
        next_cycle();
        idle();
        total++; if (v_gec !== 1'b1) begin bad++; $display("FAIL full_gecerli got=%b exp=1", v_gec); end
        total++; if (mem[8] !== 32'h1122_3344) begin bad++; $display("FAIL full_mem got=%h exp=11223344", mem[8]); end
        next_cycle();
        total++; if (v_gec !== 1'b0 || wen !== 1'b0) begin bad++; $display("FAIL full_once got gec=%b wen=%b exp 0/0", v_gec, wen); end
    endtask

    task automatic test_store_zero();
        mem[9] = 32'h5566_7788;
        vi = 1'b1; vyaz = 1'b1; vadr = 32'h0000_0024; vmaske = 4'b0000; vdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++; if (v_hazir !== 1'b1 || wen !== 1'b0) begin bad++; $display("FAIL zero_accept got hazir=%b wen=%b exp 1/0", v_hazir, wen); end
        next_cycle();
        idle();
        total++; if (v_gec !== 1'b1 || wen !== 1'b0) begin bad++; $display("FAIL zero_gecerli got gec=%b wen=%b exp 1/0", v_gec, wen); end
        next_cycle();
        total++; if (mem[9] !== 32'h5566_7788) begin bad++; $display("FAIL zero_mem got=%h exp=55667788", mem[9]); end
    endtask

    task automatic test_back_to_back();
        vi = 1'b1; vyaz = 1'b0; vadr = 32'h0000_0010;
        @(negedge clk);
        total++; if (v_hazir !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b exp=1", v_hazir); end
        next_cycle();
        vadr = 32'h0000_0023;
        @(negedge clk);
        total++; if (v_hazir !== 1'b1 || v_gec !== 1'b1 || v_veri !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL b2b_overlap got hazir=%b gec=%b veri=%h exp 1/1/deadbeef", v_hazir, v_gec, v_veri);
        end
        next_cycle();
        idle();
        total++; if (v_gec !== 1'b1 || v_veri !== 32'h1122_3344) begin bad++; $display("FAIL b2b_second got gec=%b veri=%h exp 1/11223344", v_gec, v_veri); end
        next_cycle();
    endtask

    task automatic test_masked_store();
        mem[8] = 32'hAABB_CCDD;
        mem[5] = 32'h1357_9BDF;
        bi = 1'b1; badr = 32'h0000_0010;      // lone fetch makes load/store favoured
        next_cycle();
        badr = 32'h0000_0014;
        vi = 1'b1; vyaz = 1'b1; vadr = 32'h0000_0020; vmaske = 4'b0101; vdata = 32'h1122_3344;
        @(negedge clk);
        total++; if (v_hazir !== 1'b0 || b_hazir !== 1'b0 || wen !== 1'b0) begin
            bad++; $display("FAIL mask_c1 got vh=%b bh=%b wen=%b exp 0/0/0", v_hazir, b_hazir, wen);
        end
        next_cycle();
        @(negedge clk);
        total++; if (v_hazir !== 1'b1 || wen !== 1'b1 || b_hazir !== 1'b0) begin
            bad++; $display("FAIL mask_c2 got vh=%b wen=%b bh=%b exp 1/1/0", v_hazir, wen, b_hazir);
        end
        total++; if (m_adr !== 32'h0000_0020 || m_wdata !== 32'hAA22_CC44) begin
            bad++; $display("FAIL mask_merge got adr=%h data=%h exp 00000020/aa22cc44", m_adr, m_wdata);
        end
        next_cycle();
        vi = 1'b0;
        total++; if (mem[8] !== 32'hAA22_CC44 || v_gec !== 1'b1) begin
            bad++; $display("FAIL mask_mem got mem=%h gec=%b exp aa22cc44/1", mem[8], v_gec);
        end
        @(negedge clk);
        total++; if (b_hazir !== 1'b1 || m_adr !== 32'h0000_0014) begin
            bad++; $display("FAIL mask_fetch_c3 got bh=%b adr=%h exp 1/00000014", b_hazir, m_adr);
        end
        next_cycle();
        idle();
        total++; if (b_gec !== 1'b1 || b_veri !== 32'h1357_9BDF) begin
            bad++; $display("FAIL mask_fetch_veri got gec=%b veri=%h exp 1/13579bdf", b_gec, b_veri);
        end
        next_cycle();
    endtask

    task automatic test_reset_birlestir();
        mem[10] = 32'h0102_0304;
        bi = 1'b1; badr = 32'h0000_0010;      // pointer moves away from its reset value
        next_cycle();
        bi = 1'b0;
        vi = 1'b1; vyaz = 1'b1; vadr = 32'h0000_0028; vmaske = 4'b0011; vdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++; if (v_hazir !== 1'b0) begin bad++; $display("FAIL rb_enter got=%b exp=0", v_hazir); end
        next_cycle();
        total++; if (wen !== 1'b1) begin bad++; $display("FAIL rb_wen_before got=%b exp=1", wen); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (wen !== 1'b0 || v_hazir !== 1'b0) begin bad++; $display("FAIL rb_wen_drop got wen=%b hazir=%b exp 0/0", wen, v_hazir); end
        total++; if (b_gec !== 1'b0) begin bad++; $display("FAIL rb_gec_drop got=%b exp=0", b_gec); end
        idle();
        next_cycle();
        total++; if (mem[10] !== 32'h0102_0304) begin bad++; $display("FAIL rb_mem got=%h exp=01020304", mem[10]); end
        #2 rst_n = 1'b1;
        next_cycle();
        bi = 1'b1; badr = 32'h0000_0010;
        vi = 1'b1; vyaz = 1'b0; vadr = 32'h0000_0028;
        @(negedge clk);
        total++; if (b_hazir !== 1'b1 || v_hazir !== 1'b0) begin
            bad++; $display("FAIL rb_after got bh=%b vh=%b exp 1/0", b_hazir, v_hazir);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_round_robin();
        test_fetch();
        test_store_full();
        test_store_zero();
        test_back_to_back();
        test_masked_store();
        test_reset_birlestir();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
